load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Initiator side of the word-addressed data memory port; sits in the MEM stage between the core pipeline and data_memory.
- Accepts one RV32I load/store request at a time and drives mem_read/mem_write/address/write_data.
- Sub-word stores use read-modify-write, since data memory writes whole words only.
- Loads get byte/half extraction with sign/zero extension.
- Each completed request returns one response pulse, with an error flag for misaligned access.

Parameters:
- ADDR_W, 32, width of byte address to memory
- DATA_W, 32, data word width (only 32 supported)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- req_valid  input  1  pipeline request present
- req_ready  output  1  unit idle, request accepted this edge if req_valid
- req_store  input  1  1=store, 0=load
- req_funct3  input  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  input  ADDR_W  byte address
- req_wdata  input  DATA_W  store data, low bytes used for B/H
- resp_valid  output  1  one-cycle completion pulse
- resp_err  output  1  misaligned access, valid with resp_valid
- resp_rdata  output  DATA_W  extended load result, valid with resp_valid (0 for stores/errors)
- mem_read  output  1  read strobe to data memory (memory samples on its rising edge)
- mem_write  output  1  write enable, written at next clk edge
- mem_address  output  ADDR_W  word-aligned byte address (low 2 bits always 0)
- mem_wdata  output  DATA_W  word to write
- mem_rdata  input  DATA_W  word read from memory

Behaviour:
- Reset (async): state IDLE; all outputs 0 except req_ready=1.
- Reset mid-operation: any in-flight access is abandoned; mem_write drops immediately, so no write occurs at the following edge.
- All outputs are registered. FSM states: IDLE, RD, MERGE, WR, RESP.
- IDLE: req_ready=1. On req_valid at edge N, latch funct3, addr, wdata and store flag, then go to:
  - misaligned → RESP with resp_err=1; no memory strobe ever asserted.
  - load → RD, mem_read<=1.
  - SW → WR, mem_write<=1, mem_wdata<=wdata.
  - SB/SH → RD, mem_read<=1.
- RD (one cycle, mem_read high):
  - At the edge, capture mem_rdata and set mem_read<=0.
  - Load → RESP with the extracted result.
  - Store → MERGE.
- MERGE: replace the target byte (addr[1:0]) or half (addr[1]) of the captured word with wdata[7:0] or [15:0]; set mem_wdata and mem_write<=1; go to WR.
- WR (one cycle, mem_write high): memory writes at the exiting edge; mem_write<=0; go to RESP.
- RESP: resp_valid=1 for exactly one cycle, then IDLE.
- Latency from accept edge N, resp_valid high in cycle:
  - load: N+2
  - SW: N+2
  - SB/SH: N+4
  - misaligned: N+1
- Alignment rules: H/HU need addr[0]=0; W needs addr[1:0]=0; B never misaligned. Funct3 011/110/111 are treated as misaligned (resp_err=1).
- Extraction: B sign-extends bit 7 of the selected byte, BU zero-extends; H/HU likewise on bit 15 of the selected half.
- mem_read is low for at least one cycle between any two reads, because the memory triggers on the strobe's rising edge. Back-to-back requests are therefore safe.
- mem_address = {addr[ADDR_W-1:2],2'b00}, held stable from strobe assertion through the WR/RD exit edge.
- req_ready=0 in every non-IDLE state; a req_valid held high during busy cycles is not sampled.

Optional Feature:
- Macro LSU_MISALIGN_CHECK_EN.
- Defined: alignment checking as above, with resp_err generated.
- Undefined: resp_err is tied 0 and no misalignment detection exists:
  - H/HU uses addr[1] to select the half.
  - W ignores addr[1:0].
  - Illegal funct3 is treated as W.
  - Every request performs a memory access.

Decomposition:
- Shared package lsu_pkg holds:
  - funct3 localparams F3_B, F3_H, F3_W, F3_BU, F3_HU
  - FSM state encoding
- One natural sub-module: lsu_align. It is purely combinational: load extraction/extension plus store byte-lane merge. It is reused by MERGE and RD capture.

Test Plan:
- Memory word 0x40 = 0x8899AABB; LW addr 0x40 → resp_valid at N+2, resp_rdata=0x8899AABB, exactly one mem_read pulse.
- Same word: LB addr 0x41 → 0xFFFFFFAA; LBU addr 0x41 → 0x000000AA; LH addr 0x42 → 0xFFFF8899; LHU → 0x00008899.
- SB addr 0x43 wdata 0x12 → mem_write at N+3 with mem_wdata=0x1299AABB; subsequent LW 0x40 reads 0x1299AABB; resp at N+4.
- SW addr 0x44 data 0xDEADBEEF then immediate LW 0x44 → 0xDEADBEEF; check mem_read low between consecutive loads.
- LW addr 0x42 (macro defined) → resp_err=1 at N+1, no mem_read/mem_write. Macro undefined → reads word 0x40.
- Assert reset during WR of SW → mem_write low immediately, memory word unchanged; req_ready=1 after release.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - RV32I funct3 encodings for memory accesses
//   - FSM state encoding
//   - alignment / store-width helpers
// Used with optional macro LSU_MISALIGN_CHECK_EN (see load_store_unit.sv).
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD    = 3'd1,
    S_MERGE = 3'd2,
    S_WR    = 3'd3,
    S_RESP  = 3'd4
  } lsu_state_t;

  // Reserved funct3 codes (011/110/111) count as misaligned so they
  // terminate without touching memory.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
    logic bad;
    case (f3)
      F3_B, F3_BU: bad = 1'b0;
      F3_H, F3_HU: bad = addr_lo[0];
      F3_W:        bad = (addr_lo != 2'b00);
      default:     bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Byte and half stores need a read-modify-write; everything else is a
  // full-word write (including reserved codes when no checking is built in).
  function automatic logic is_subword_store(input logic [2:0] f3);
    return ~f3[1];
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational byte-lane logic for the load/store unit.
//   funct3    in  access size/sign
//   addr_lo   in  byte offset within the word
//   word      in  memory word (live read data or captured word)
//   wdata     in  store data, low bytes used for B/H
//   load_data out extracted and sign/zero-extended load result
//   merged    out word with the store bytes inserted
// H/HU always select the half with addr_lo[1]; addr_lo[0] is not looked at,
// which is what the unchecked build relies on.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [4:0]  lane_lsb;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign lane_lsb = {addr_lo, 3'b000};

  always_comb begin
    byte_sel = word[lane_lsb +: 8];
    half_sel = addr_lo[1] ? word[31:16] : word[15:0];

    case (funct3)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_data = {24'h0, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_data = {16'h0, half_sel};
      default: load_data = word;
    endcase

    merged = word;
    case (funct3[1:0])
      2'b00: merged[lane_lsb +: 8] = wdata[7:0];
      2'b01: begin
        if (addr_lo[1]) merged[31:16] = wdata[15:0];
        else            merged[15:0]  = wdata[15:0];
      end
      default: merged = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage initiator for the word-addressed data memory.
// One RV32I load/store at a time; sub-word stores are read-modify-write.
//   clk, reset           clock, async active-high reset
//   req_valid/req_ready  request handshake (accepted in IDLE only)
//   req_store/funct3/addr/wdata  request fields
//   resp_valid/err/rdata one-cycle completion pulse with result
//   mem_read/mem_write/mem_address/mem_wdata/mem_rdata  memory port
// Optional macro LSU_MISALIGN_CHECK_EN: when defined, misaligned or reserved
// funct3 requests complete with resp_err=1 and no memory access; when
// undefined, resp_err stays 0 and every request accesses memory.
//
// state  | meaning
// IDLE   | ready for a request
// RD     | mem_read high, word captured at exit edge
// MERGE  | insert store bytes into captured word
// WR     | mem_write high, memory written at exit edge
// RESP   | resp_valid pulse
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  lsu_state_t        state;
  logic [2:0]        f3_q;
  logic [1:0]        addr_lo_q;
  logic [DATA_W-1:0] wdata_q;
  logic              store_q;
  logic [DATA_W-1:0] rdata_q;

  logic              misalign;
  logic [DATA_W-1:0] align_word;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] merged;

`ifdef LSU_MISALIGN_CHECK_EN
  assign misalign = is_misaligned(req_funct3, req_addr[1:0]);
`else
  assign misalign = 1'b0;
`endif

  // One aligner serves both paths: live memory data during RD (load
  // extraction) and the captured word during MERGE (store insertion).
  assign align_word = (state == S_RD) ? mem_rdata : rdata_q;

  lsu_align u_align (
    .funct3    (f3_q),
    .addr_lo   (addr_lo_q),
    .word      (align_word),
    .wdata     (wdata_q),
    .load_data (load_data),
    .merged    (merged)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      f3_q        <= 3'b000;
      addr_lo_q   <= 2'b00;
      wdata_q     <= '0;
      store_q     <= 1'b0;
      rdata_q     <= '0;
      req_ready   <= 1'b1;
      resp_valid  <= 1'b0;
      resp_err    <= 1'b0;
      resp_rdata  <= '0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_address <= '0;
      mem_wdata   <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            f3_q        <= req_funct3;
            addr_lo_q   <= req_addr[1:0];
            wdata_q     <= req_wdata;
            store_q     <= req_store;
            req_ready   <= 1'b0;
            mem_address <= {req_addr[ADDR_W-1:2], 2'b00};
            if (misalign) begin
              state      <= S_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else if (req_store && !is_subword_store(req_funct3)) begin
              state     <= S_WR;
              mem_write <= 1'b1;
              mem_wdata <= req_wdata;
            end else begin
              state    <= S_RD;
              mem_read <= 1'b1;
            end
          end
        end
        S_RD: begin
          mem_read <= 1'b0;
          rdata_q  <= mem_rdata;
          if (store_q) begin
            state <= S_MERGE;
          end else begin
            state      <= S_RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= load_data;
          end
        end
        S_MERGE: begin
          mem_wdata <= merged;
          mem_write <= 1'b1;
          state     <= S_WR;
        end
        S_WR: begin
          mem_write  <= 1'b0;
          state      <= S_RESP;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
        end
        S_RESP: begin
          state      <= S_IDLE;
          req_ready  <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
        end
        default: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_store = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;

  load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // memory: read data presented after the rising edge of the strobe
  logic [31:0] mem [0:63];
  always @(posedge clk) if (mem_write) mem[mem_address[7:2]] <= mem_wdata;
  always @(posedge mem_read) begin
    #1 mem_rdata = mem[mem_address[7:2]];
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          nrd;
    int          nwr;
    int          wr_lat;
    logic [31:0] wdata;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   rd_cnt = 0, wr_cnt = 0, wr_cyc = 0;
  logic prev_rd = 1'b0;
  logic [31:0] wr_data = '0;

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (mem_read) begin
      if (prev_rd) chk("rd_gap", {31'b0, prev_rd}, 32'd0);
      rd_cnt++;
    end
    prev_rd = mem_read;
    if (mem_write) begin
      wr_cnt++;
      wr_cyc  = cyc;
      wr_data = mem_wdata;
    end
    if (resp_valid) begin
      if (sb.size() == 0) begin
        chk("unexp_resp", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("resp_err", {31'b0, resp_err}, {31'b0, e.err});
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("latency", cyc - e.acc, e.lat);
        chk("n_reads", rd_cnt, e.nrd);
        chk("n_writes", wr_cnt, e.nwr);
        if (e.nwr != 0) begin
          chk("wr_latency", wr_cyc - e.acc, e.wr_lat);
          chk("wr_data", wr_data, e.wdata);
        end
      end
      rd_cnt = 0;
      wr_cnt = 0;
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic e_err, input logic [31:0] e_rd,
                        input int e_lat, input int e_nrd, input int e_nwr,
                        input int e_wlat, input logic [31:0] e_wd);
    exp_t e;
    int   n = 0;
    wait_ready();
    @(negedge clk);
    #1;
    req_valid  = 1'b1;
    req_store  = st;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    @(posedge clk);
    e.err = e_err; e.rdata = e_rd; e.lat = e_lat; e.nrd = e_nrd; e.nwr = e_nwr;
    e.wr_lat = e_wlat; e.wdata = e_wd; e.acc = cyc;
    sb.push_back(e);
    #1 req_valid = 1'b0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("resp_timeout", 32'd0, 32'd1);
      sb.delete();
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[16] = 32'h8899AABB;

    repeat (3) @(negedge clk);
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_mem_read", {31'b0, mem_read}, 32'd0);
    chk("rst_mem_write", {31'b0, mem_write}, 32'd0);
    chk("rst_mem_address", mem_address, 32'd0);
    reset = 1'b0;
    rd_cnt = 0; wr_cnt = 0;

    // loads of word 0x40
    do_req(0, F3_W,  32'h40, 0, 0, 32'h8899AABB, 2, 1, 0, 0, 0);
    do_req(0, F3_B,  32'h41, 0, 0, 32'hFFFFFFAA, 2, 1, 0, 0, 0);
    do_req(0, F3_BU, 32'h41, 0, 0, 32'h000000AA, 2, 1, 0, 0, 0);
    do_req(0, F3_H,  32'h42, 0, 0, 32'hFFFF8899, 2, 1, 0, 0, 0);
    do_req(0, F3_HU, 32'h42, 0, 0, 32'h00008899, 2, 1, 0, 0, 0);

    // sub-word store then read back
    do_req(1, F3_B, 32'h43, 32'h12, 0, 32'h0, 4, 1, 1, 3, 32'h1299AABB);
    do_req(0, F3_W, 32'h40, 0, 0, 32'h1299AABB, 2, 1, 0, 0, 0);

    // full-word store, back-to-back loads
    do_req(1, F3_W, 32'h44, 32'hDEADBEEF, 0, 32'h0, 2, 0, 1, 1, 32'hDEADBEEF);
    do_req(0, F3_W, 32'h44, 0, 0, 32'hDEADBEEF, 2, 1, 0, 0, 0);
    do_req(0, F3_W, 32'h44, 0, 0, 32'hDEADBEEF, 2, 1, 0, 0, 0);
    do_req(1, F3_H, 32'h46, 32'h0000CAFE, 0, 32'h0, 4, 1, 1, 3, 32'hCAFEBEEF);
    do_req(0, F3_H, 32'h46, 0, 0, 32'hFFFFCAFE, 2, 1, 0, 0, 0);
    do_req(0, F3_BU, 32'h47, 0, 0, 32'h000000CA, 2, 1, 0, 0, 0);

`ifdef LSU_MISALIGN_CHECK_EN
    do_req(0, F3_W, 32'h42, 0, 1, 32'h0, 1, 0, 0, 0, 0);
    do_req(0, F3_H, 32'h41, 0, 1, 32'h0, 1, 0, 0, 0, 0);
    do_req(0, 3'b011, 32'h40, 0, 1, 32'h0, 1, 0, 0, 0, 0);
    do_req(1, F3_W, 32'h41, 32'h11111111, 1, 32'h0, 1, 0, 0, 0, 0);
    do_req(0, F3_W, 32'h40, 0, 0, 32'h1299AABB, 2, 1, 0, 0, 0);
`else
    do_req(0, F3_W, 32'h42, 0, 0, 32'h1299AABB, 2, 1, 0, 0, 0);
    do_req(0, F3_H, 32'h41, 0, 0, 32'hFFFFAABB, 2, 1, 0, 0, 0);
    do_req(0, 3'b011, 32'h40, 0, 0, 32'h1299AABB, 2, 1, 0, 0, 0);
`endif

    // reset during WR of a word store: write must not happen
    wait_ready();
    @(negedge clk);
    #1;
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = F3_W;
    req_addr = 32'h48; req_wdata = 32'h55555555;
    @(posedge clk);
    #1 req_valid = 1'b0;
    chk("wr_before_rst", {31'b0, mem_write}, 32'd1);
    reset = 1'b1;
    #1 chk("wr_drop_on_rst", {31'b0, mem_write}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    rd_cnt = 0; wr_cnt = 0;
    #1;
    chk("mem_unchanged", mem[18], 32'h0);
    chk("ready_after_rst", {31'b0, req_ready}, 32'd1);
    chk("no_resp_after_rst", {31'b0, resp_valid}, 32'd0);
    do_req(0, F3_W, 32'h48, 0, 0, 32'h0, 2, 1, 0, 0, 0);
    do_req(0, F3_W, 32'h40, 0, 0, 32'h1299AABB, 2, 1, 0, 0, 0);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
